// File: rtl/pixgain_nch_if.sv
`default_nettype none
// ============================================================================
// Module   : pixgain_nch_if
// Purpose  : Beat, gain and frame-statistics signal bundle for pixgain_nch.
// Revision : 1.0  initial release
// ============================================================================
interface pixgain_nch_if #(
  parameter int NCH    = 10,
  parameter int DW_IN  = 10,
  parameter int DW_OUT = 8,
  parameter int GAINW  = 2,
  parameter int CNTW   = 20
);
  logic                    i_fs;
  logic [GAINW-1:0]        i_gain;
  logic                    i_din_vld;
  logic [NCH*DW_IN-1:0]    i_din;
  logic                    o_dout_vld;
  logic [NCH*DW_OUT-1:0]   o_dout;
  logic [GAINW-1:0]        o_gain_act;
  logic                    o_stat_vld;
  logic [CNTW-1:0]         o_sat_cnt;
  logic [DW_IN-1:0]        o_peak;

  modport master (
    output i_fs, i_gain, i_din_vld, i_din,
    input  o_dout_vld, o_dout, o_gain_act, o_stat_vld, o_sat_cnt, o_peak
  );

  modport slave (
    input  i_fs, i_gain, i_din_vld, i_din,
    output o_dout_vld, o_dout, o_gain_act, o_stat_vld, o_sat_cnt, o_peak
  );
endinterface
`default_nettype wire

// File: rtl/pixgain_nch.sv
`default_nettype none
// ============================================================================
// Module   : pixgain_nch
// Purpose  : N-channel pixel gain/requantiser with frame-locked gain and
//            per-frame saturation count / peak statistics.
//            Optional macro PIXGAIN_ROUND_EN: round-half-up before the shift.
// Revision : 1.0  initial release
// ============================================================================
module pixgain_nch #(
  parameter int NCH    = 10,
  parameter int DW_IN  = 10,
  parameter int DW_OUT = 8,
  parameter int GAINW  = 2,
  parameter int CNTW   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  pixgain_nch_if.slave       bus
);

  localparam int               C_DIFF_I = DW_IN - DW_OUT;
  localparam int               C_NW     = $clog2(NCH + 1);
  localparam logic [GAINW-1:0] C_DIFF   = GAINW'(C_DIFF_I);
  localparam logic [DW_IN:0]   C_MAXOUT = {{(DW_IN + 1 - DW_OUT){1'b0}}, {DW_OUT{1'b1}}};

  // Gain selection: a gain presented with fs applies to the fs beat itself.
  logic [GAINW-1:0]        r_gain_act;
  logic [GAINW-1:0]        w_gain_eff;
  logic [GAINW-1:0]        w_g;

  assign w_gain_eff = bus.i_fs ? bus.i_gain : r_gain_act;
  assign w_g        = (w_gain_eff > C_DIFF) ? C_DIFF : w_gain_eff;

  logic                    r_s1_vld;
  logic [NCH*DW_IN-1:0]    r_s1_din;
  logic [GAINW-1:0]        r_s1_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gain_act <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_din   <= '0;
      r_s1_g     <= '0;
    end else begin
      if (bus.i_fs) begin
        r_gain_act <= bus.i_gain;
      end
      r_s1_vld <= bus.i_din_vld;
      if (bus.i_din_vld) begin
        r_s1_din <= bus.i_din;
        r_s1_g   <= w_g;
      end
    end
  end

  logic [GAINW-1:0]        w_s;
  logic [DW_IN-1:0]        w_x [NCH];
  logic [DW_OUT-1:0]       w_y [NCH];
  logic [NCH-1:0]          w_sat;

  assign w_s = C_DIFF - r_s1_g;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DW_IN:0] w_ext;
    logic [DW_IN:0] w_sh;

    assign w_x[k] = r_s1_din[k*DW_IN +: DW_IN];
`ifdef PIXGAIN_ROUND_EN
    // Extra MSB keeps the rounding carry so it can force saturation.
    logic [DW_IN:0] w_half;
    assign w_half = (w_s == '0) ? '0
                  : ({{DW_IN{1'b0}}, 1'b1} << (w_s - {{(GAINW-1){1'b0}}, 1'b1}));
    assign w_ext  = {1'b0, w_x[k]} + w_half;
`else
    assign w_ext  = {1'b0, w_x[k]};
`endif
    assign w_sh     = w_ext >> w_s;
    assign w_sat[k] = (w_sh > C_MAXOUT);
    assign w_y[k]   = w_sat[k] ? {DW_OUT{1'b1}} : w_sh[DW_OUT-1:0];
  end

  logic [C_NW-1:0]         w_satn;
  logic [DW_IN-1:0]        w_bmax;
  logic [NCH*DW_OUT-1:0]   w_y_pk;

  always_comb begin
    w_satn = '0;
    w_bmax = '0;
    w_y_pk = '0;
    for (int k = 0; k < NCH; k++) begin
      w_satn = w_satn + C_NW'(w_sat[k]);
      if (w_x[k] > w_bmax) begin
        w_bmax = w_x[k];
      end
      w_y_pk[k*DW_OUT +: DW_OUT] = w_y[k];
    end
  end

  // Statistics are taken from stage1, so a beat counts in the frame it was accepted in.
  logic [CNTW-1:0]         r_run_cnt;
  logic [DW_IN-1:0]        r_run_pk;
  logic [C_NW-1:0]         w_add;
  logic [DW_IN-1:0]        w_bpk;
  logic [CNTW:0]           w_sum;
  logic [CNTW-1:0]         w_cnt_next;
  logic [DW_IN-1:0]        w_pk_next;

  assign w_add      = r_s1_vld ? w_satn : '0;
  assign w_bpk      = r_s1_vld ? w_bmax : '0;
  assign w_sum      = {1'b0, r_run_cnt} + (CNTW+1)'(w_add);
  assign w_cnt_next = w_sum[CNTW] ? {CNTW{1'b1}} : w_sum[CNTW-1:0];
  assign w_pk_next  = (w_bpk > r_run_pk) ? w_bpk : r_run_pk;

  logic                    r_stat_vld;
  logic [CNTW-1:0]         r_sat_cnt;
  logic [DW_IN-1:0]        r_peak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_cnt  <= '0;
      r_run_pk   <= '0;
      r_stat_vld <= 1'b0;
      r_sat_cnt  <= '0;
      r_peak     <= '0;
    end else if (bus.i_fs) begin
      r_sat_cnt  <= w_cnt_next;
      r_peak     <= w_pk_next;
      r_stat_vld <= 1'b1;
      r_run_cnt  <= '0;
      r_run_pk   <= '0;
    end else begin
      r_stat_vld <= 1'b0;
      r_run_cnt  <= w_cnt_next;
      r_run_pk   <= w_pk_next;
    end
  end

  logic                    r_dout_vld;
  logic [NCH*DW_OUT-1:0]   r_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_vld <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_dout_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_dout <= w_y_pk;
      end
    end
  end

  assign bus.o_dout_vld = r_dout_vld;
  assign bus.o_dout     = r_dout;
  assign bus.o_gain_act = r_gain_act;
  assign bus.o_stat_vld = r_stat_vld;
  assign bus.o_sat_cnt  = r_sat_cnt;
  assign bus.o_peak     = r_peak;

endmodule
`default_nettype wire
